dm_access_ctrl: RTL and testbench

Data-memory access controller sitting directly downstream of the MEM stage: consumes its `chip_select`, active-low byte write enables `w_eb` and store data `DM_in`, and drives a variable-latency memory port with a req/ready handshake. Stalls the pipeline until each access completes and returns byte-lane-aligned read data on `DM_out` for the MEM stage's load extension. Lets the core use memories slower than one cycle.

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_load_align.sv | 13 +
 rtl/dm_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_dm_access_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory access controller.
// Optional feature macro used by this slice: DM_ACCESS_TIMEOUT_EN.
package dm_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    // Active-low write-enable pattern that marks a load.
    localparam logic [3:0] BE_READ = 4'b1111;

    // Default number of REQ cycles before a bus error is flagged.
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dm_load_align.sv
// Load alignment: shifts the read word right by the addressed byte lane so
// the addressed byte lands in [7:0]; vacated upper bytes are zero-filled.
module dm_load_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            lane_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = word_i >> {lane_i, 3'b000};

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller between the MEM stage and a variable-latency
// memory port with req/ready handshake. Holds the pipeline until each access
// completes and returns lane-aligned load data on DM_out.
// Optional feature: define DM_ACCESS_TIMEOUT_EN to enable the REQ timeout
// counter and the sticky bus_err flag; otherwise REQ waits indefinitely.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_select,
    input  logic [3:0]            w_eb,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] DM_in,
    output logic [DATA_WIDTH-1:0] DM_out,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_err
);

    dm_state_e             state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [3:0]            mem_be_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] dm_out_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] rdata_aligned;
    logic                  timeout_hit;
    logic                  is_write;

    assign is_write = (w_eb != BE_READ);

    dm_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .word_i (mem_rdata),
        .lane_i (lane_q),
        .data_o (rdata_aligned)
    );

`ifdef DM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // Expiry only when the last allowed REQ cycle passes without ready;
    // a ready in that same cycle takes priority as a normal completion.
    assign timeout_hit = (state_q == REQ) && !mem_ready &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // REQ cycle counter (cleared on entry to REQ) and sticky bus error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && chip_select) begin
                cnt_q <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // Access FSM: latch the request in IDLE, hold it in REQ until ready, one DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dm_out_q    <= '0;
            lane_q      <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chip_select) begin
                        state_q     <= REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_write;
                        mem_be_q    <= is_write ? ~w_eb : BE_READ;
                        mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= DM_in;
                        lane_q      <= addr[1:0];
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            dm_out_q <= rdata_aligned;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // The pipeline is held from the cycle the access is seen until it completes.
    assign stall = ~rst & (((state_q == IDLE) & chip_select) | (state_q == REQ));

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign DM_out    = dm_out_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a scoreboard of expected DM_out values.
// Timeout scenarios are included when DM_ACCESS_TIMEOUT_EN is defined.
module tb_dm_access_ctrl;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        chip_select;
    logic [3:0]  w_eb;
    logic [31:0] addr;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_dm;

    dm_access_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .chip_select (chip_select),
        .w_eb        (w_eb),
        .addr        (addr),
        .DM_in       (DM_in),
        .DM_out      (DM_out),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access: ready is given in REQ cycle n. Inputs are scrambled
    // during REQ to show the request fields were latched.
    task automatic access(input logic [31:0] a, input logic [3:0] web,
                          input logic [31:0] din, input logic [31:0] rdata,
                          input int n, input bit flush,
                          output int done_cyc, output int req_cyc);
        logic [31:0] exp_addr;
        logic [31:0] got;
        logic        exp_we;
        logic [3:0]  exp_be;
        int          stalls;
        exp_we   = (web != 4'b1111);
        exp_be   = exp_we ? ~web : 4'b1111;
        exp_addr = {a[31:2], 2'b00};
        if (!exp_we) exp_dm = rdata >> (a[1:0] * 8);
        exp_q.push_back(exp_dm);

        @(negedge clk);
        chip_select = 1'b1; addr = a; w_eb = web; DM_in = din; mem_ready = 1'b0;
        #1;
        chk("stall_idle", {31'd0, stall}, 32'd1);
        chk("req_idle", {31'd0, mem_req}, 32'd0);
        stalls  = 1;
        req_cyc = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) req_cyc = cyc;
            addr  = $urandom;
            DM_in = $urandom;
            w_eb  = 4'($urandom);
            if (flush) chip_select = 1'b0;
            if (i == n) begin
                mem_ready = 1'b1; mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0; mem_rdata = $urandom;
            end
            #1;
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, din);
            if (stall) stalls++;
        end
        @(negedge clk);
        mem_ready = 1'b0; chip_select = 1'b0; mem_rdata = $urandom;
        #1;
        done_cyc = cyc;
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("req_done", {31'd0, mem_req}, 32'd0);
        chk("stall_cycles", stalls, n + 1);
        got = exp_q.pop_front();
        chk("dm_out", DM_out, got);
    endtask

    initial begin
        int d1, r1, d2, r2;
        rst = 1'b1; chip_select = 1'b1; w_eb = 4'b1111; addr = 32'h0;
        DM_in = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0; exp_dm = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_dm_out", DM_out, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0; chip_select = 1'b0;

        // Word read, immediate ready
        access(32'h0000_0104, 4'b1111, 32'h1234_5678, 32'hAABB_CCDD, 1, 1'b0, d1, r1);
        // Byte read from top lane
        access(32'h0000_0107, 4'b1111, 32'h0, 32'h1122_3344, 2, 1'b0, d1, r1);
        // Byte store, ready after 5 REQ cycles; DM_out keeps 0x11
        access(32'h0000_0202, 4'b1011, 32'h00AB_0000, 32'h5555_5555, 5, 1'b0, d1, r1);

        // Ready outside REQ is ignored
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray_req", {31'd0, mem_req}, 32'd0);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("stray_dm_out", DM_out, 32'h0000_0011);

        // Back-to-back load then store
        access(32'h0000_0301, 4'b1111, 32'h0, 32'hCAFE_F00D, 3, 1'b0, d1, r1);
        access(32'h0000_0300, 4'b0000, 32'h0BAD_BEEF, 32'h0, 1, 1'b0, d2, r2);
        chk("b2b_gap", r2 - d1, 32'd2);

        // Flush: chip_select drops during REQ, access still completes
        access(32'h0000_0402, 4'b1111, 32'h0, 32'h89AB_CDEF, 2, 1'b1, d1, r1);

        // Reset in the middle of REQ
        @(negedge clk);
        chip_select = 1'b1; addr = 32'h0000_0500; w_eb = 4'b1111;
        @(negedge clk);
        chip_select = 1'b0;
        #1;
        chk("mid_req_up", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_dm = 32'h0;
        #1;
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_be", {28'd0, mem_be}, 32'd0);
        chk("post_rst_addr", mem_addr, 32'd0);
        chk("post_rst_dm_out", DM_out, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        access(32'h0000_0600, 4'b1111, 32'h0, 32'h0102_0304, 1, 1'b0, d1, r1);

`ifdef DM_ACCESS_TIMEOUT_EN
        // Ready on the last allowed REQ cycle completes normally
        access(32'h0000_0704, 4'b1111, 32'h0, 32'h7777_7777, TO, 1'b0, d1, r1);
        chk("to_edge_bus_err", {31'd0, bus_err}, 32'd0);
        // Ready never asserted: request dropped after TO REQ cycles
        @(negedge clk);
        chip_select = 1'b1; addr = 32'h0000_0708; w_eb = 4'b1111;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chip_select = 1'b0;
            #1;
            chk("to_req_held", {31'd0, mem_req}, 32'd1);
            chk("to_no_err_yet", {31'd0, bus_err}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_dm_out", DM_out, exp_dm);
        repeat (3) @(negedge clk);
        #1;
        chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`else
        chk("bus_err_tied", {31'd0, bus_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
